// File: rtl/softmax_norm_sequencer.sv
// Softmax normalization sequencer: buffers one vector of Q4.12 exponentials, scales each
// in place by a shared Q0.16 reciprocal via an external multiplier, then streams results out.
module softmax_norm_sequencer #(
    parameter int BIT_WIDTH = 16,
    parameter int NUM_ELEM  = 32,
    parameter int IDX_W     = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [BIT_WIDTH-1:0] i_recip,
    input  logic                 i_in_valid,
    input  logic [BIT_WIDTH-1:0] i_in_data,
    output logic                 o_in_ready,
    output logic                 o_mul_valid,
    output logic [BIT_WIDTH-1:0] o_mul_dataA,
    output logic [BIT_WIDTH-1:0] o_mul_dataB,
    input  logic [BIT_WIDTH-1:0] i_mul_data,
    input  logic                 i_mul_valid,
    output logic                 o_out_valid,
    output logic [BIT_WIDTH-1:0] o_out_data,
    output logic                 o_out_last,
    input  logic                 i_out_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ELEM - 1);

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [BIT_WIDTH-1:0] recip_reg, recip_next;
    logic                 err_reg, err_next;

    // Asynchronous-read storage: the multiplier and output port see buffer[idx]
    // in the same cycle the index is presented.
    logic [BIT_WIDTH-1:0] buffer_mem [NUM_ELEM];
    logic                 buf_we;
    logic [BIT_WIDTH-1:0] buf_wdata;
    logic                 idx_at_last;

    assign idx_at_last = (idx_reg == IDX_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            recip_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            recip_reg <= recip_next;
            err_reg   <= err_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (buf_we) begin
            buffer_mem[idx_reg] <= buf_wdata;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        recip_next  = recip_reg;
        err_next    = err_reg;
        buf_we      = 1'b0;
        buf_wdata   = i_in_data;
        o_in_ready  = 1'b0;
        o_mul_valid = 1'b0;
        o_mul_dataA = '0;
        o_mul_dataB = '0;
        o_out_valid = 1'b0;
        o_out_data  = '0;
        o_out_last  = 1'b0;
        o_done      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (i_start) begin
                    recip_next = i_recip;
                    idx_next   = '0;
                    err_next   = 1'b0;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    buf_we    = 1'b1;
                    buf_wdata = i_in_data;
                    if (idx_at_last) begin
                        idx_next   = '0;
                        state_next = S_RUN;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            S_RUN: begin
                o_mul_valid = 1'b1;
                o_mul_dataA = buffer_mem[idx_reg];
                o_mul_dataB = recip_reg;
                // The product is written back even when flagged invalid; the error is sticky.
                buf_we      = 1'b1;
                buf_wdata   = i_mul_data;
                if (!i_mul_valid) begin
                    err_next = 1'b1;
                end
                if (idx_at_last) begin
                    idx_next   = '0;
                    state_next = S_OUT;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            S_OUT: begin
                o_out_valid = 1'b1;
                o_out_data  = buffer_mem[idx_reg];
                o_out_last  = idx_at_last;
                if (i_out_ready) begin
                    if (idx_at_last) begin
                        idx_next   = '0;
                        state_next = S_DONE;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            S_DONE: begin
                o_done     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    assign o_busy = (state_reg != S_IDLE);
    assign o_err  = err_reg;

endmodule

// File: tb/tb_softmax_norm_sequencer.sv
// Directed bench for softmax_norm_sequencer with a behavioural rounding/clamping multiplier.
module tb_softmax_norm_sequencer;

    localparam int N = 32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] recip;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        mul_valid;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [15:0] mul_data;
    logic        mul_vld_in;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp;
    int n_bad;
    int cyc;
    int done_seen;
    int b_seen;
    int b_bad;
    logic [15:0] exp_b;
    logic        mul_vld_en;
    logic [15:0] vec [N];
    logic [15:0] got_data [$];
    logic        got_last [$];

    softmax_norm_sequencer #(.BIT_WIDTH(16), .NUM_ELEM(N)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_recip     (recip),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_mul_valid (mul_valid),
        .o_mul_dataA (mul_a),
        .o_mul_dataB (mul_b),
        .i_mul_data  (mul_data),
        .i_mul_valid (mul_vld_in),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .i_out_ready (out_ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: round(A*B >> 12) with negative results clamped to zero.
    logic signed [33:0] prod;
    logic signed [33:0] rnd;
    always_comb begin
        prod     = $signed(mul_a) * $signed({1'b0, mul_b});
        rnd      = (prod + 34'sd2048) >>> 12;
        mul_data = 16'h0000;
        if (rnd > 34'sd65535)
            mul_data = 16'hFFFF;
        else if (rnd >= 0)
            mul_data = rnd[15:0];
    end
    assign mul_vld_in = mul_vld_en;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (mul_valid === 1'b1) begin
            b_seen++;
            if (mul_b !== exp_b) b_bad++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_vec(input logic [15:0] r, output int t0);
        start = 1'b1;
        recip = r;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
        recip = 16'h0000;
    endtask

    task automatic load_vec(input bit gaps, input bit busy_start);
        for (int k = 0; k < N; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            if (busy_start && k == 10) begin
                start = 1'b1;
                recip = 16'hFFFF;
            end
            in_valid = 1'b1;
            in_data  = vec[k];
            tick();
            in_valid = 1'b0;
            in_data  = 16'h0000;
            start    = 1'b0;
            recip    = 16'h0000;
        end
    endtask

    task automatic collect_out(output int timed_out);
        bit fin;
        fin = 0;
        timed_out = 1;
        got_data.delete();
        got_last.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (out_valid === 1'b1) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                if (out_last === 1'b1) fin = 1;
            end
            tick();
            if (fin) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if ({mul_valid, mul_a, mul_b} !== 33'd0) begin n_bad++; $display("FAIL reset_mul got=%b/%h/%h exp=0/0/0", mul_valid, mul_a, mul_b); end
        n_cmp++; if ({out_valid, out_data, out_last, done, err} !== 20'd0) begin n_bad++; $display("FAIL reset_out got=%b/%h/%b/%b/%b exp=0", out_valid, out_data, out_last, done, err); end
        $display("reset: outputs idle");
    endtask

    task automatic test_basic();
        int t0, to;
        for (int k = 0; k < N; k++) vec[k] = 16'h1000;
        start_vec(16'h0800, t0);
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL basic_load_state got ready=%b busy=%b exp=1/1", in_ready, busy); end
        load_vec(0, 0);
        collect_out(to);
        n_cmp++; if (to != 0 || got_data.size() != N) begin n_bad++; $display("FAIL basic_count got=%0d exp=%0d timeout=%0d", got_data.size(), N, to); end
        for (int k = 0; k < got_data.size(); k++) begin
            n_cmp++; if (got_data[k] !== 16'h0800 || got_last[k] !== (k == N - 1)) begin n_bad++; $display("FAIL basic_elem%0d got=%h last=%b exp=0800 last=%b", k, got_data[k], got_last[k], k == N - 1); end
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL basic_done got=%b exp=1", done); end
        n_cmp++; if (cyc - t0 + 2 != 3 * N + 2) begin n_bad++; $display("FAIL basic_latency got=%0d exp=%0d", cyc - t0 + 2, 3 * N + 2); end
        tick();
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got done=%b busy=%b exp=0/0", done, busy); end
        $display("basic: %0d elements, %0d cycles start to done", got_data.size(), cyc - t0 + 1);
    endtask

    task automatic test_backpressure();
        int t0, n, p, held;
        bit r, prev_stall, fin;
        logic [15:0] prev_data;
        for (int k = 0; k < N; k++) vec[k] = 16'(k * 256);
        start_vec(16'h0400, t0);
        load_vec(0, 0);
        n = 0; p = 0; held = 0; prev_stall = 0; fin = 0; prev_data = 16'h0;
        for (int c = 0; c < 600; c++) begin
            if (out_valid === 1'b1) begin
                if (prev_stall) begin
                    n_cmp++; if (out_data !== prev_data) begin n_bad++; $display("FAIL bp_stable got=%h exp=%h", out_data, prev_data); end
                end
                if (n == N - 1) begin r = (held >= 5); held++; end
                else begin r = (p % 3 == 0); p++; end
                out_ready = r;
                if (r) begin
                    n_cmp++; if (out_data !== 16'(n * 64) || out_last !== (n == N - 1)) begin n_bad++; $display("FAIL bp_elem%0d got=%h last=%b exp=%h last=%b", n, out_data, out_last, 16'(n * 64), n == N - 1); end
                    if (out_last === 1'b1) fin = 1;
                    n++;
                end
                prev_stall = !r;
                prev_data  = out_data;
            end else begin
                prev_stall = 0;
            end
            tick();
            if (fin) break;
        end
        out_ready = 1'b1;
        n_cmp++; if (n != N || done !== 1'b1) begin n_bad++; $display("FAIL bp_count got=%0d done=%b exp=%0d done=1", n, done, N); end
        tick();
        $display("backpressure: %0d elements accepted", n);
    endtask

    task automatic test_gaps_busy_start();
        int t0, to;
        for (int k = 0; k < N; k++) vec[k] = 16'h1000;
        exp_b = 16'h0800;
        b_seen = 0;
        b_bad = 0;
        start_vec(16'h0800, t0);
        load_vec(1, 1);
        start = 1'b1;
        recip = 16'hFFFF;
        tick();
        start = 1'b0;
        recip = 16'h0000;
        collect_out(to);
        n_cmp++; if (to != 0 || got_data.size() != N) begin n_bad++; $display("FAIL gaps_count got=%0d exp=%0d", got_data.size(), N); end
        for (int k = 0; k < got_data.size(); k++) begin
            n_cmp++; if (got_data[k] !== 16'h0800) begin n_bad++; $display("FAIL gaps_elem%0d got=%h exp=0800", k, got_data[k]); end
        end
        n_cmp++; if (b_seen != N || b_bad != 0) begin n_bad++; $display("FAIL gaps_recip got seen=%0d bad=%0d exp=%0d/0", b_seen, b_bad, N); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL gaps_no_restart got busy=%b exp=0", busy); end
        $display("gaps: %0d elements, %0d RUN cycles", got_data.size(), b_seen);
    endtask

    task automatic test_negative_ramp();
        int t0, to;
        logic [15:0] e;
        for (int k = 0; k < N; k++) vec[k] = 16'(k * 256);
        vec[5] = 16'hF000;
        start_vec(16'h0400, t0);
        load_vec(0, 0);
        collect_out(to);
        n_cmp++; if (to != 0 || got_data.size() != N) begin n_bad++; $display("FAIL ramp_count got=%0d exp=%0d", got_data.size(), N); end
        for (int k = 0; k < got_data.size(); k++) begin
            e = (k == 5) ? 16'h0000 : 16'(k * 64);
            n_cmp++; if (got_data[k] !== e) begin n_bad++; $display("FAIL ramp_elem%0d got=%h exp=%h", k, got_data[k], e); end
        end
        tick();
        $display("ramp: %0d elements", got_data.size());
    endtask

    task automatic test_reset_mid();
        int t0, to;
        for (int k = 0; k < N; k++) vec[k] = 16'h1000;
        done_seen = 0;
        start_vec(16'h0800, t0);
        load_vec(0, 0);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if ({busy, mul_valid, mul_a, mul_b, out_valid, out_data, in_ready} !== 52'd0) begin n_bad++; $display("FAIL rst_run got busy=%b mulv=%b a=%h b=%h exp=0", busy, mul_valid, mul_a, mul_b); end
        start_vec(16'h0800, t0);
        load_vec(0, 0);
        repeat (N) tick();
        out_ready = 1'b1;
        repeat (20) tick();
        out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        n_cmp++; if ({busy, out_valid, out_data, out_last, mul_valid} !== 20'd0) begin n_bad++; $display("FAIL rst_out got busy=%b ov=%b od=%h ol=%b exp=0", busy, out_valid, out_data, out_last); end
        tick();
        n_cmp++; if (done_seen != 0) begin n_bad++; $display("FAIL rst_no_done got=%0d exp=0", done_seen); end
        start_vec(16'h0800, t0);
        load_vec(0, 0);
        collect_out(to);
        n_cmp++; if (to != 0 || got_data.size() != N) begin n_bad++; $display("FAIL rst_fresh_count got=%0d exp=%0d", got_data.size(), N); end
        for (int k = 0; k < got_data.size(); k++) begin
            n_cmp++; if (got_data[k] !== 16'h0800) begin n_bad++; $display("FAIL rst_fresh_elem%0d got=%h exp=0800", k, got_data[k]); end
        end
        tick();
        $display("reset_mid: fresh vector %0d elements", got_data.size());
    endtask

    task automatic test_mul_fault();
        int t0, to;
        for (int k = 0; k < N; k++) vec[k] = 16'h1000;
        start_vec(16'h0800, t0);
        load_vec(0, 0);
        repeat (3) tick();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL fault_pre got=%b exp=0", err); end
        mul_vld_en = 1'b0;
        tick();
        mul_vld_en = 1'b1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL fault_rise got=%b exp=1", err); end
        collect_out(to);
        n_cmp++; if (done !== 1'b1 || err !== 1'b1) begin n_bad++; $display("FAIL fault_hold got done=%b err=%b exp=1/1", done, err); end
        tick();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL fault_idle got=%b exp=1", err); end
        start_vec(16'h0800, t0);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL fault_clear got=%b exp=0", err); end
        load_vec(0, 0);
        collect_out(to);
        tick();
        n_cmp++; if (to != 0 || err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL fault_clean_run got err=%b busy=%b to=%0d exp=0/0/0", err, busy, to); end
        $display("mul_fault: error flagged and cleared");
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; done_seen = 0; b_seen = 0; b_bad = 0;
        exp_b = 16'h0800;
        rst_n = 1'b0; start = 1'b0; recip = 16'h0; in_valid = 1'b0; in_data = 16'h0;
        out_ready = 1'b1; mul_vld_en = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps_busy_start();
        test_negative_ramp();
        test_reset_mid();
        test_mul_fault();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
